// File: rtl/aes_block_sequencer_if.sv
// Handshake and engine bundle for aes_block_sequencer.
// master = host plus engine side (drives requests and engine results); slave = the sequencer.
interface aes_block_sequencer_if #(
  parameter int BLOCK_W = 128
);
  logic               in_valid;
  logic               in_ready;
  logic [BLOCK_W-1:0] in_block;
  logic               in_decrypt;
  logic               in_first;
  logic [BLOCK_W-1:0] iv;
  logic [BLOCK_W-1:0] key;
  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] out_block;
  logic               err;
  logic [BLOCK_W-1:0] eng_data;
  logic [BLOCK_W-1:0] eng_key;
  logic               eng_start_enc;
  logic               eng_start_dec;
  logic               eng_done_enc;
  logic               eng_done_dec;
  logic [BLOCK_W-1:0] eng_cipher;
  logic [BLOCK_W-1:0] eng_plain;

  modport master (
    output in_valid, in_block, in_decrypt, in_first, iv, key, out_ready,
           eng_done_enc, eng_done_dec, eng_cipher, eng_plain,
    input  in_ready, out_valid, out_block, err,
           eng_data, eng_key, eng_start_enc, eng_start_dec
  );

  modport slave (
    input  in_valid, in_block, in_decrypt, in_first, iv, key, out_ready,
           eng_done_enc, eng_done_dec, eng_cipher, eng_plain,
    output in_ready, out_valid, out_block, err,
           eng_data, eng_key, eng_start_enc, eng_start_dec
  );
endinterface

// File: rtl/aes_block_sequencer.sv
// Single-block-in-flight sequencer between a host block stream and an AES encrypt/decrypt engine pair.
// Define AES_SEQ_CBC_EN for CBC chaining; left undefined the block is pure ECB with no chain register.
module aes_block_sequencer #(
  parameter int BLOCK_W     = 128,
  parameter int TIMEOUT_CYC = 64
) (
  input logic                  clk,
  input logic                  reset,
  aes_block_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t             state;
  logic               dec_q;
  logic               armed;
  logic [CNT_W-1:0]   cnt;
  logic               done_match;
  logic [BLOCK_W-1:0] chain_cur;
  logic [BLOCK_W-1:0] chain_sel;

`ifdef AES_SEQ_CBC_EN
  logic [BLOCK_W-1:0] chain;
  assign chain_cur = chain;
  assign chain_sel = bus.in_first ? bus.iv : chain;
`else
  assign chain_cur = '0;
  assign chain_sel = '0;
`endif

  assign done_match = dec_q ? bus.eng_done_dec : bus.eng_done_enc;

  // NOTE: all state and outputs update with <= so every branch sees the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      dec_q             <= 1'b0;
      armed             <= 1'b0;
      cnt               <= '0;
      bus.in_ready      <= 1'b1;
      bus.out_valid     <= 1'b0;
      bus.out_block     <= '0;
      bus.err           <= 1'b0;
      bus.eng_data      <= '0;
      bus.eng_key       <= '0;
      bus.eng_start_enc <= 1'b0;
      bus.eng_start_dec <= 1'b0;
`ifdef AES_SEQ_CBC_EN
      chain             <= '0;
`endif
    end else begin
      bus.err           <= 1'b0;
      bus.eng_start_enc <= 1'b0;
      bus.eng_start_dec <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            dec_q             <= bus.in_decrypt;
            bus.eng_key       <= bus.key;
            // eng_data doubles as the captured block: it is the ciphertext on decrypt.
            bus.eng_data      <= bus.in_decrypt ? bus.in_block : (bus.in_block ^ chain_sel);
`ifdef AES_SEQ_CBC_EN
            chain             <= chain_sel;
`endif
            bus.eng_start_enc <= ~bus.in_decrypt;
            bus.eng_start_dec <= bus.in_decrypt;
            bus.in_ready      <= 1'b0;
            state             <= ISSUE;
          end
        end

        ISSUE: begin
          cnt   <= '0;
          armed <= 1'b0;
          state <= WAIT;
        end

        WAIT: begin
          cnt <= cnt + 1'b1;
          // A done left high by the previous operation is ignored until seen low once.
          if (!done_match) armed <= 1'b1;
          if (armed && done_match) begin
            bus.out_valid <= 1'b1;
            if (dec_q) begin
              bus.out_block <= bus.eng_plain ^ chain_cur;
`ifdef AES_SEQ_CBC_EN
              chain         <= bus.eng_data;
`endif
            end else begin
              bus.out_block <= bus.eng_cipher;
`ifdef AES_SEQ_CBC_EN
              chain         <= bus.eng_cipher;
`endif
            end
            state <= OUT;
          end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            bus.err      <= 1'b1;
            bus.in_ready <= 1'b1;
            state        <= IDLE;
          end
        end

        OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_block_sequencer.sv
// Self-checking bench for aes_block_sequencer: behavioural engine, chaining reference model, random traffic.
// Follows AES_SEQ_CBC_EN the same way the design does (CBC when defined, ECB otherwise).
module tb_aes_block_sequencer;
  localparam int TO = 16;
  localparam logic [127:0] VEC_K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] VEC_P  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] VEC_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] MAGIC  = 128'h5a5a_c3c3_0ff0_1234_89ab_cdef_7654_3210;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  aes_block_sequencer_if bus ();
  aes_block_sequencer #(.BLOCK_W(128), .TIMEOUT_CYC(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  // Engine model controls and observations.
  int           eng_lat    = 12;
  bit           eng_sticky = 1'b0;
  bit           eng_never  = 1'b0;
  int           enc_starts = 0;
  int           dec_starts = 0;
  logic [127:0] e_last_data = '0;

  logic [127:0] m_chain = '0;

  // Stand-in cipher: the known vector pair maps exactly, anything else goes through an invertible mix.
  function automatic logic [127:0] toy_enc(input logic [127:0] x, input logic [127:0] k);
    logic [127:0] r;
    if (x == VEC_P && k == VEC_K) return VEC_C;
    r = {x[120:0], x[127:121]} ^ k ^ MAGIC;
    return r;
  endfunction

  function automatic logic [127:0] toy_dec(input logic [127:0] y, input logic [127:0] k);
    logic [127:0] t;
    if (y == VEC_C && k == VEC_K) return VEC_P;
    t = y ^ k ^ MAGIC;
    return {t[6:0], t[127:7]};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Engine: samples start at the falling edge, answers eng_lat cycles later with a pulse or sticky done.
  initial begin
    int           left;
    int           clr;
    bit           pend;
    bit           fire;
    logic         edec;
    logic [127:0] ein;
    logic [127:0] ek;
    left = 0; clr = 0; pend = 1'b0; edec = 1'b0; ein = '0; ek = '0;
    bus.eng_done_enc = 1'b0;
    bus.eng_done_dec = 1'b0;
    bus.eng_cipher   = '0;
    bus.eng_plain    = '0;
    forever begin
      @(negedge clk);
      fire = 1'b0;
      if (pend) begin
        left--;
        if (left == 0) begin
          pend = 1'b0;
          fire = !eng_never;
        end
      end
      if (fire) begin
        if (edec) begin
          bus.eng_plain    = toy_dec(ein, ek);
          bus.eng_done_dec = 1'b1;
        end else begin
          bus.eng_cipher   = toy_enc(ein, ek);
          bus.eng_done_enc = 1'b1;
        end
      end else if (!eng_sticky) begin
        bus.eng_done_enc = 1'b0;
        bus.eng_done_dec = 1'b0;
      end else if (clr > 0) begin
        clr--;
        if (clr == 0) begin
          bus.eng_done_enc = 1'b0;
          bus.eng_done_dec = 1'b0;
        end
      end
      if (bus.eng_start_enc || bus.eng_start_dec) begin
        pend = 1'b1;
        left = eng_lat;
        clr  = 2;
        edec = bus.eng_start_dec;
        ein  = bus.eng_data;
        ek   = bus.eng_key;
        e_last_data = bus.eng_data;
        if (bus.eng_start_enc) enc_starts++;
        if (bus.eng_start_dec) dec_starts++;
      end
    end
  end

  // Reference model: expected engine input and result for one accepted block.
  task automatic model_block(input logic dec, input logic first, input logic [127:0] blk,
                             input logic [127:0] ivv, input logic [127:0] k,
                             output logic [127:0] exp_out, output logic [127:0] exp_data);
    logic [127:0] c;
`ifdef AES_SEQ_CBC_EN
    if (first) m_chain = ivv;
    c = m_chain;
`else
    c = '0;
`endif
    exp_data = dec ? blk : (blk ^ c);
    exp_out  = dec ? (toy_dec(blk, k) ^ c) : toy_enc(blk ^ c, k);
  endtask

  task automatic model_commit(input logic dec, input logic [127:0] blk, input logic [127:0] exp_out);
    m_chain = dec ? blk : exp_out;
  endtask

  // Drives one block through both handshakes; reports what was observed, compares nothing itself.
  task automatic run_block(input logic dec, input logic first, input logic [127:0] blk,
                           input logic [127:0] ivv, input logic [127:0] k, input int stall,
                           output logic [127:0] obs, output logic got, output logic start_ok,
                           output logic hold_ok, output logic ready_after);
    int n;
    obs = '0; got = 1'b0; start_ok = 1'b0; hold_ok = 1'b1; ready_after = 1'b0;
    bus.in_valid = 1'b1; bus.in_decrypt = dec; bus.in_first = first;
    bus.in_block = blk; bus.iv = ivv; bus.key = k;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_block = ~blk; bus.iv = ~ivv; bus.key = ~k;
    start_ok = dec ? (bus.eng_start_dec && !bus.eng_start_enc) : (bus.eng_start_enc && !bus.eng_start_dec);
    n = 0;
    while (!bus.out_valid && n < TO + 40) begin @(negedge clk); n++; end
    if (!bus.out_valid) return;
    got = 1'b1;
    obs = bus.out_block;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!bus.out_valid || bus.out_block !== obs || bus.in_ready) hold_ok = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    ready_after = bus.in_ready && !bus.out_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.err !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.err); else n_pass++;
    n_checks++; if ({bus.eng_start_enc, bus.eng_start_dec} !== 2'b00)
      $display("FAIL reset_starts: got %b%b want 00", bus.eng_start_enc, bus.eng_start_dec); else n_pass++;
    n_checks++; if (bus.eng_data !== '0 || bus.eng_key !== '0 || bus.out_block !== '0)
      $display("FAIL reset_data: got data=%h key=%h out=%h want all 0", bus.eng_data, bus.eng_key, bus.out_block);
    else n_pass++;
    m_chain = '0;
  endtask

  task automatic test_vectors();
    logic [127:0] obs, eo, ed;
    logic got, s_ok, h_ok, r_ok;
    int es0, ds0;
    eng_sticky = 1'b0; eng_lat = 12;
    es0 = enc_starts;
    model_block(1'b0, 1'b1, VEC_P, '0, VEC_K, eo, ed);
    run_block(1'b0, 1'b1, VEC_P, '0, VEC_K, 0, obs, got, s_ok, h_ok, r_ok);
    model_commit(1'b0, VEC_P, eo);
    n_checks++; if (obs !== VEC_C) $display("FAIL vec_enc_out: got %h want %h", obs, VEC_C); else n_pass++;
    n_checks++; if (enc_starts - es0 != 1) $display("FAIL vec_enc_starts: got %0d want 1", enc_starts - es0); else n_pass++;
    n_checks++; if (s_ok !== 1'b1) $display("FAIL vec_enc_start_latency: got %b want 1", s_ok); else n_pass++;
    n_checks++; if (r_ok !== 1'b1) $display("FAIL vec_enc_ready_after: got %b want 1", r_ok); else n_pass++;

    es0 = enc_starts; ds0 = dec_starts;
    model_block(1'b1, 1'b1, VEC_C, '0, VEC_K, eo, ed);
    run_block(1'b1, 1'b1, VEC_C, '0, VEC_K, 0, obs, got, s_ok, h_ok, r_ok);
    model_commit(1'b1, VEC_C, eo);
    n_checks++; if (obs !== VEC_P) $display("FAIL vec_dec_out: got %h want %h", obs, VEC_P); else n_pass++;
    n_checks++; if (enc_starts != es0) $display("FAIL vec_dec_no_enc: got %0d enc starts want 0", enc_starts - es0); else n_pass++;
    n_checks++; if (dec_starts - ds0 != 1) $display("FAIL vec_dec_starts: got %0d want 1", dec_starts - ds0); else n_pass++;
  endtask

  task automatic test_cbc();
    logic [127:0] iv0, p1, c0, c1, obs, e0, e1, ed0, ed1, eo;
    logic got, s_ok, h_ok, r_ok;
    iv0 = 128'h0f0e0d0c0b0a09080706050403020100;
    p1  = ~VEC_P;
    model_block(1'b0, 1'b1, VEC_P, iv0, VEC_K, e0, ed0);
    run_block(1'b0, 1'b1, VEC_P, iv0, VEC_K, 0, c0, got, s_ok, h_ok, r_ok);
    model_commit(1'b0, VEC_P, e0);
    n_checks++; if (c0 !== e0) $display("FAIL cbc_c0: got %h want %h", c0, e0); else n_pass++;

    model_block(1'b0, 1'b0, p1, ~iv0, VEC_K, e1, ed1);
    run_block(1'b0, 1'b0, p1, ~iv0, VEC_K, 0, c1, got, s_ok, h_ok, r_ok);
    model_commit(1'b0, p1, e1);
    n_checks++; if (e_last_data !== ed1) $display("FAIL cbc_eng_data_blk2: got %h want %h", e_last_data, ed1); else n_pass++;
    n_checks++; if (c1 !== e1) $display("FAIL cbc_c1: got %h want %h", c1, e1); else n_pass++;

    model_block(1'b1, 1'b1, c0, iv0, VEC_K, eo, ed0);
    run_block(1'b1, 1'b1, c0, iv0, VEC_K, 0, obs, got, s_ok, h_ok, r_ok);
    model_commit(1'b1, c0, eo);
    n_checks++; if (obs !== VEC_P) $display("FAIL cbc_p0: got %h want %h", obs, VEC_P); else n_pass++;

    model_block(1'b1, 1'b0, c1, ~iv0, VEC_K, eo, ed0);
    run_block(1'b1, 1'b0, c1, ~iv0, VEC_K, 0, obs, got, s_ok, h_ok, r_ok);
    model_commit(1'b1, c1, eo);
    n_checks++; if (obs !== p1) $display("FAIL cbc_p1: got %h want %h", obs, p1); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [127:0] blk, k, obs, eo, ed;
    logic got, s_ok, h_ok, r_ok;
    blk = rnd128(); k = rnd128();
    model_block(1'b0, 1'b0, blk, '0, k, eo, ed);
    run_block(1'b0, 1'b0, blk, '0, k, 10, obs, got, s_ok, h_ok, r_ok);
    model_commit(1'b0, blk, eo);
    n_checks++; if (h_ok !== 1'b1) $display("FAIL stall_hold: got %b want 1", h_ok); else n_pass++;
    n_checks++; if (obs !== eo) $display("FAIL stall_out: got %h want %h", obs, eo); else n_pass++;
    n_checks++; if (r_ok !== 1'b1) $display("FAIL stall_ready_after: got %b want 1", r_ok); else n_pass++;
  endtask

  task automatic test_sticky();
    logic [127:0] blk, k, obs, eo, ed;
    logic got, s_ok, h_ok, r_ok, dec;
    eng_sticky = 1'b1; eng_lat = 12;
    k = rnd128();
    for (int i = 0; i < 3; i++) begin
      blk = rnd128();
      dec = (i == 1);
      model_block(dec, 1'b0, blk, '0, k, eo, ed);
      run_block(dec, 1'b0, blk, '0, k, 0, obs, got, s_ok, h_ok, r_ok);
      model_commit(dec, blk, eo);
      n_checks++; if (obs !== eo) $display("FAIL sticky_out[%0d]: got %h want %h", i, obs, eo); else n_pass++;
    end
    eng_sticky = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic [127:0] blk, k, obs, eo, ed;
    logic got, s_ok, h_ok, r_ok, saw_out;
    int n;
    eng_never = 1'b1;
    blk = rnd128(); k = rnd128();
    model_block(1'b0, 1'b0, blk, '0, k, eo, ed);
    bus.in_valid = 1'b1; bus.in_decrypt = 1'b0; bus.in_first = 1'b0; bus.in_block = blk; bus.key = k;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0; saw_out = 1'b0;
    while (!bus.err && n < TO + 10) begin
      @(negedge clk); n++;
      if (bus.out_valid) saw_out = 1'b1;
    end
    // The ISSUE cycle precedes WAIT entry, so err lands TO cycles after that plus one.
    n_checks++; if (n != TO + 1) $display("FAIL timeout_latency: got %0d want %0d", n, TO + 1); else n_pass++;
    n_checks++; if (saw_out !== 1'b0) $display("FAIL timeout_no_out: got %b want 0", saw_out); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL timeout_idle: got %b want 1", bus.in_ready); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.err !== 1'b0) $display("FAIL timeout_err_pulse: got %b want 0", bus.err); else n_pass++;
    eng_never = 1'b0;

    blk = rnd128();
    model_block(1'b0, 1'b0, blk, '0, k, eo, ed);
    run_block(1'b0, 1'b0, blk, '0, k, 0, obs, got, s_ok, h_ok, r_ok);
    model_commit(1'b0, blk, eo);
    n_checks++; if (obs !== eo) $display("FAIL timeout_chain_kept: got %h want %h", obs, eo); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic saw;
    int n;
    eng_lat = 8;
    bus.in_valid = 1'b1; bus.in_decrypt = 1'b0; bus.in_first = 1'b1;
    bus.in_block = rnd128(); bus.iv = rnd128(); bus.key = rnd128();
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_chain = '0;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.eng_data !== '0) $display("FAIL rstmid_eng_data: got %h want 0", bus.eng_data); else n_pass++;
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid || !bus.in_ready) saw = 1'b1;
    end
    n_checks++; if (saw !== 1'b0) $display("FAIL rstmid_late_done: got %b want 0", saw); else n_pass++;
    eng_lat = 12;
  endtask

  task automatic test_random();
    logic [127:0] blk, ivv, k, obs, eo, ed;
    logic got, s_ok, h_ok, r_ok, dec, first;
    for (int i = 0; i < 24; i++) begin
      dec   = $urandom_range(0, 1) == 1;
      first = $urandom_range(0, 3) == 0;
      blk = rnd128(); ivv = rnd128();
      k = ($urandom_range(0, 3) == 0) ? VEC_K : rnd128();
      eng_lat    = $urandom_range(3, 15);
      eng_sticky = $urandom_range(0, 1) == 1;
      model_block(dec, first, blk, ivv, k, eo, ed);
      run_block(dec, first, blk, ivv, k, $urandom_range(0, 3), obs, got, s_ok, h_ok, r_ok);
      model_commit(dec, blk, eo);
      n_checks++;
      if (obs !== eo || e_last_data !== ed || !got || !s_ok || !h_ok || !r_ok)
        $display("FAIL random[%0d]: got out=%h data=%h flags=%b%b%b%b want out=%h data=%h flags=1111",
                 i, obs, e_last_data, got, s_ok, h_ok, r_ok, eo, ed);
      else n_pass++;
    end
    eng_sticky = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_decrypt = 1'b0; bus.in_first = 1'b0;
    bus.in_block = '0; bus.iv = '0; bus.key = '0; bus.out_ready = 1'b0;
    test_reset();
    test_vectors();
    test_cbc();
    test_backpressure();
    test_sticky();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
